// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies LENGTH bytes from a 256-byte source page into OAM,
// one byte per clock, with a one-cycle read-to-write pipeline.
module oam_dma_ctrl #(
    parameter int LENGTH      = 160,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    input  logic [7:0]  trig_page,
    output logic [7:0]  page_rd,
    output logic        busy,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_d_in,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_d_wr,
    output logic        oam_write
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_XFER} state_t;

    localparam logic [8:0] CNT_LAST = 9'(LENGTH - 1);
    localparam logic [3:0] DLY_LAST = 4'((START_DELAY > 0) ? (START_DELAY - 1) : 0);

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  dly_q, dly_d;
    logic        wv_q, wv_d;
    logic [7:0]  widx_q, widx_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [15:0] last_addr_q, last_addr_d;

    logic [7:0]  page_eff;
    logic [15:0] rd_addr;

    // Pages 0xE0..0xFF alias onto 0xC0..0xDF.
    assign page_eff = (page_q >= 8'hE0) ? (page_q & 8'hDF) : page_q;
    assign rd_addr  = {page_eff, cnt_q[7:0]};

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        wv_d        = 1'b0;
        widx_d      = widx_q;
        wdat_d      = wdat_q;
        last_addr_d = last_addr_q;

        case (state_q)
            S_DELAY: begin
                if (dly_q == DLY_LAST) state_d = S_XFER;
                else                   dly_d   = dly_q + 4'd1;
            end
            S_XFER: begin
                wv_d        = 1'b1;
                widx_d      = cnt_q[7:0];
                wdat_d      = src_d_in;
                last_addr_d = rd_addr;
                cnt_d       = cnt_q + 9'd1;
                if (cnt_q == CNT_LAST) state_d = S_IDLE;
            end
            default: ;
        endcase

        // A trigger restarts the sequence from any state; a byte read this
        // cycle has already been captured above and still gets written.
        if (trig) begin
            page_d  = trig_page;
            cnt_d   = 9'd0;
            dly_d   = 4'd0;
            state_d = (START_DELAY == 0) ? S_XFER : S_DELAY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            page_q      <= 8'h00;
            cnt_q       <= 9'd0;
            dly_q       <= 4'd0;
            wv_q        <= 1'b0;
            widx_q      <= 8'h00;
            wdat_q      <= 8'h00;
            last_addr_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            wv_q        <= wv_d;
            widx_q      <= widx_d;
            wdat_q      <= wdat_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign page_rd   = page_q;
    assign busy      = (state_q != S_IDLE) || wv_q;
    assign src_addr  = (state_q == S_XFER) ? rd_addr : last_addr_q;
    assign oam_addr  = widx_q;
    assign oam_d_wr  = wdat_q;
    assign oam_write = wv_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: default instance plus a START_DELAY=0, LENGTH=4 instance.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        rst_n;

    logic        trig;
    logic [7:0]  trig_page;
    logic [7:0]  page_rd;
    logic        busy;
    logic [15:0] src_addr;
    logic [7:0]  src_d_in;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_d_wr;
    logic        oam_write;

    logic        s_trig;
    logic [7:0]  s_trig_page;
    logic [7:0]  s_page_rd;
    logic        s_busy;
    logic [15:0] s_src_addr;
    logic [7:0]  s_src_d_in;
    logic [7:0]  s_oam_addr;
    logic [7:0]  s_oam_d_wr;
    logic        s_oam_write;

    int checks = 0;
    int failures = 0;

    // Source memory model: byte k of any page holds k ^ 0x5A.
    assign src_d_in   = src_addr[7:0] ^ 8'h5A;
    assign s_src_d_in = s_src_addr[7:0] ^ 8'h5A;

    oam_dma_ctrl dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .trig_page(trig_page),
        .page_rd(page_rd), .busy(busy), .src_addr(src_addr), .src_d_in(src_d_in),
        .oam_addr(oam_addr), .oam_d_wr(oam_d_wr), .oam_write(oam_write)
    );

    oam_dma_ctrl #(.LENGTH(4), .START_DELAY(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .trig(s_trig), .trig_page(s_trig_page),
        .page_rd(s_page_rd), .busy(s_busy), .src_addr(s_src_addr), .src_d_in(s_src_d_in),
        .oam_addr(s_oam_addr), .oam_d_wr(s_oam_d_wr), .oam_write(s_oam_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Caller raises trig in cycle 0; this walks cycles 1..ncyc of a default
    // transfer (D=1, LENGTH=160) and checks every output against the timeline.
    // pend/pidx describe a byte left over from an interrupted transfer that
    // must be written in cycle 1.
    task automatic check_xfer(input logic [7:0] eff, input bit pend, input logic [7:0] pidx,
                              input int ncyc, output int nwr);
        logic       exp_busy, exp_wr;
        logic [7:0] idx;
        nwr = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (c == 1) trig = 1'b0;
            exp_busy = (c <= 162);
            exp_wr   = (c >= 3 && c <= 162) || (c == 1 && pend);
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL busy cycle %0d: got %b want %b", c, busy, exp_busy);
            end
            checks++;
            if (oam_write !== exp_wr) begin
                failures++;
                $display("FAIL oam_write cycle %0d: got %b want %b", c, oam_write, exp_wr);
            end
            if (exp_wr) begin
                nwr++;
                idx = (c == 1) ? pidx : 8'(c - 3);
                checks++;
                if (oam_addr !== idx || oam_d_wr !== (idx ^ 8'h5A)) begin
                    failures++;
                    $display("FAIL oam_data cycle %0d: got addr %h data %h want addr %h data %h",
                             c, oam_addr, oam_d_wr, idx, idx ^ 8'h5A);
                end
            end
            if (c >= 2 && c <= 161) begin
                checks++;
                if (src_addr !== {eff, 8'(c - 2)}) begin
                    failures++;
                    $display("FAIL src_addr cycle %0d: got %h want %h", c, src_addr, {eff, 8'(c - 2)});
                end
            end
        end
    endtask

    task automatic fire(input logic [7:0] pg);
        trig      = 1'b1;
        trig_page = pg;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; trig = 1'b0; trig_page = 8'h00; s_trig = 1'b0; s_trig_page = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, src_addr, oam_addr, oam_d_wr, oam_write, page_rd} !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b src=%h oa=%h od=%h ow=%b pg=%h want all zero",
                     busy, src_addr, oam_addr, oam_d_wr, oam_write, page_rd);
        end
        checks++;
        if ({s_busy, s_src_addr, s_oam_write, s_page_rd} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs_small: got busy=%b src=%h ow=%b pg=%h want all zero",
                     s_busy, s_src_addr, s_oam_write, s_page_rd);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input logic [7:0] pg, input logic [7:0] eff);
        int n;
        fire(pg);
        check_xfer(eff, 1'b0, 8'h00, 165, n);
        checks++;
        if (n != 160) begin
            failures++;
            $display("FAIL write_count page %h: got %0d want 160", pg, n);
        end
        checks++;
        if (page_rd !== pg) begin
            failures++;
            $display("FAIL page_rd: got %h want %h", page_rd, pg);
        end
    endtask

    task automatic test_retrigger;
        int n;
        fire(8'h80);
        check_xfer(8'h80, 1'b0, 8'h00, 52, n);  // cycle 52 reads byte 50 at 0x8032
        fire(8'h90);
        check_xfer(8'h90, 1'b1, 8'd50, 165, n);
        checks++;
        if (n != 161) begin
            failures++;
            $display("FAIL retrig_write_count: got %0d want 161", n);
        end
        checks++;
        if (page_rd !== 8'h90) begin
            failures++;
            $display("FAIL retrig_page_rd: got %h want 90", page_rd);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        fire(8'hC1);
        check_xfer(8'hC1, 1'b0, 8'h00, 82, n);  // reading byte 80
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, src_addr, oam_addr, oam_d_wr, oam_write, page_rd} !== 42'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got busy=%b src=%h oa=%h od=%h ow=%b pg=%h want all zero",
                     busy, src_addr, oam_addr, oam_d_wr, oam_write, page_rd);
        end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (oam_write !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL after_reset cycle %0d: got write=%b busy=%b want 0 0", c, oam_write, busy);
            end
        end
        fire(8'h33);
        check_xfer(8'h33, 1'b0, 8'h00, 165, n);
        checks++;
        if (n != 160) begin
            failures++;
            $display("FAIL post_reset_count: got %0d want 160", n);
        end
    endtask

    task automatic test_final_cycle_trig;
        int n;
        fire(8'h44);
        check_xfer(8'h44, 1'b0, 8'h00, 162, n);  // cycle 162 carries the last write
        checks++;
        if (n != 160) begin
            failures++;
            $display("FAIL final_first_count: got %0d want 160", n);
        end
        fire(8'h55);
        check_xfer(8'h55, 1'b0, 8'h00, 165, n);
        checks++;
        if (n != 160 || page_rd !== 8'h55) begin
            failures++;
            $display("FAIL final_second: got count %0d page %h want 160 55", n, page_rd);
        end
    endtask

    task automatic test_short;
        logic       exp_busy, exp_wr;
        logic [7:0] idx;
        s_trig = 1'b1; s_trig_page = 8'h12;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 1) s_trig = 1'b0;
            exp_busy = (c <= 5);
            exp_wr   = (c >= 2 && c <= 5);
            checks++;
            if (s_busy !== exp_busy || s_oam_write !== exp_wr) begin
                failures++;
                $display("FAIL short_ctrl cycle %0d: got busy=%b wr=%b want busy=%b wr=%b",
                         c, s_busy, s_oam_write, exp_busy, exp_wr);
            end
            if (exp_wr) begin
                idx = 8'(c - 2);
                checks++;
                if (s_oam_addr !== idx || s_oam_d_wr !== (idx ^ 8'h5A)) begin
                    failures++;
                    $display("FAIL short_data cycle %0d: got %h/%h want %h/%h",
                             c, s_oam_addr, s_oam_d_wr, idx, idx ^ 8'h5A);
                end
            end
            if (c <= 4) begin
                checks++;
                if (s_src_addr !== {8'h12, 8'(c - 1)}) begin
                    failures++;
                    $display("FAIL short_src cycle %0d: got %h want %h", c, s_src_addr, {8'h12, 8'(c - 1)});
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic(8'hC1, 8'hC1);
        test_basic(8'hFE, 8'hDE);
        test_retrigger;
        test_reset_mid;
        test_short;
        test_final_cycle_trig;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
